// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM states and iteration-engine op select for alu_mc.
package alu_mc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        IT_MUL = 1'b0,
        IT_DIV = 1'b1
    } iter_op_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared WIDTH-step engine: shift-add multiply or restoring divide.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  iter_op_e         op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    iter_op_e         op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH-1:0] hi_n, lo_n, dif;
    logic [WIDTH:0]   sum, shl;
    logic             ge, last;

    // hi:lo is product (mul) or remainder:quotient (div)
    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl = {hi_q, lo_q[WIDTH-1]};
        ge  = shl >= {1'b0, b_q};
        dif = shl[WIDTH-1:0] - b_q;
        if (op_q == IT_MUL) begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_n = ge ? dif : shl[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end
    end

    assign last     = cnt_q == CNT_W'(WIDTH - 1);
    assign done_o   = busy_q && last;
    assign result_o = lo_n;
    assign rem_o    = hi_n;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            op_d   = op_i;
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
        end else if (busy_q) begin
            hi_d = hi_n;
            lo_d = lo_n;
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= IT_MUL;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub single-cycle, mul/div/mod iterative.
// Define ALU_MC_FLAGS_EN to add the flags_o {zero, carry, overflow} output.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
`ifdef ALU_MC_FLAGS_EN
    output logic [2:0]       flags_o,
`endif
    output logic             err_o
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             it_start, it_done;
    iter_op_e         it_op;
    logic [WIDTH-1:0] it_res, it_rem;

    alu_mc_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (it_start),
        .op_i     (it_op),
        .a_i      (data0_i),
        .b_i      (data1_i),
        .done_o   (it_done),
        .result_o (it_res),
        .rem_o    (it_rem)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        it_start = 1'b0;
        it_op    = IT_MUL;
        unique case (state_q)
            ST_IDLE: if (valid_i) begin
                op_d    = ctrl_i;
                err_d   = 1'b0;
                state_d = ST_DONE;
                case (ctrl_i)
                    OP_ADD: result_d = data0_i + data1_i;
                    OP_SUB: result_d = data0_i - data1_i;
                    OP_MUL: begin
                        it_start = 1'b1;
                        state_d  = ST_BUSY;
                    end
                    OP_DIV, OP_MOD: begin
                        if (data1_i == '0) begin
                            result_d = (ctrl_i == OP_DIV) ? '1 : data0_i;
                            err_d    = 1'b1;
                        end else begin
                            it_start = 1'b1;
                            it_op    = IT_DIV;
                            state_d  = ST_BUSY;
                        end
                    end
                    default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                endcase
            end
            ST_BUSY: if (it_done) begin
                result_d = (op_q == OP_MOD) ? it_rem : it_res;
                err_d    = 1'b0;
                state_d  = ST_DONE;
            end
            ST_DONE: if (ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign ready_o  = state_q == ST_IDLE;
    assign valid_o  = state_q == ST_DONE;
    assign result_o = result_q;
    assign err_o    = err_q;

`ifdef ALU_MC_FLAGS_EN
    logic [2:0] flags_q, flags_d;

    // Flags latch together with the result on entry to DONE
    always_comb begin
        flags_d = flags_q;
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            flags_d[2] = result_d == '0;
            flags_d[1] = state_q == ST_IDLE &&
                ((ctrl_i == OP_ADD && (data0_i + data1_i) < data0_i) ||
                 (ctrl_i == OP_SUB && data0_i < data1_i));
            flags_d[0] = state_q == ST_BUSY && op_q == OP_MUL &&
                it_rem != '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) flags_q <= '0;
        else         flags_q <= flags_d;
    end

    assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): vector table, random ops, reset abort.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [2:0]   ctrl_i = '0;
    logic [W-1:0] data0_i = '0;
    logic [W-1:0] data1_i = '0;
    logic         ready_o, valid_o, err_o;
    logic [W-1:0] result_o;
`ifdef ALU_MC_FLAGS_EN
    logic [2:0]   flags_o;
`endif

    int total = 0;
    int bad = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ctrl_i   (ctrl_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
`ifdef ALU_MC_FLAGS_EN
        .flags_o  (flags_o),
`endif
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] c;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] r;
        logic       e;
        int         lat;
        logic [2:0] f;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Plain-arithmetic reference: result, error, latency and flags
    function automatic void model(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic e, output int lat,
                                  output logic [2:0] f);
        int unsigned ia, ib, p;
        logic cy, ov;
        ia = a; ib = b; e = 1'b0; lat = 1; cy = 1'b0; ov = 1'b0;
        case (c)
            3'd0: begin p = ia + ib; r = 8'(p % 256); cy = p > 255; end
            3'd1: begin r = 8'((ia + 256 - ib) % 256); cy = ia < ib; end
            3'd2: begin p = ia * ib; r = 8'(p % 256); ov = p > 255; lat = W + 1; end
            3'd3: if (ib == 0) begin r = 8'hFF; e = 1'b1; end
                  else begin r = 8'(ia / ib); lat = W + 1; end
            3'd4: if (ib == 0) begin r = a; e = 1'b1; end
                  else begin r = 8'(ia % ib); lat = W + 1; end
            default: begin r = 8'd0; e = 1'b1; end
        endcase
        f = {r == 8'd0, cy, ov};
    endfunction

    task automatic run(input string tag, input logic [2:0] c, input logic [7:0] a,
                       input logic [7:0] b, input int hold, input bit noise,
                       input logic [7:0] er, input logic ee, input int elat,
                       input logic [2:0] ef);
        int lat, rdy_seen;
        @(negedge clk);
        chk({tag, " ready_idle"}, ready_o, 1);
        valid_i = 1'b1; ctrl_i = c; data0_i = a; data1_i = b;
        @(negedge clk);
        valid_i = 1'b0;
        ctrl_i = 3'($urandom); data0_i = 8'($urandom); data1_i = 8'($urandom);
        lat = 1; rdy_seen = 0;
        while (!valid_o && lat < 40) begin
            if (ready_o) rdy_seen++;
            if (noise) begin
                valid_i = 1'($urandom);
                ctrl_i = 3'($urandom); data0_i = 8'($urandom); data1_i = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " valid"}, valid_o, 1);
        chk({tag, " result"}, result_o, er);
        chk({tag, " err"}, err_o, ee);
        chk({tag, " busy_ready"}, rdy_seen, 0);
`ifdef ALU_MC_FLAGS_EN
        chk({tag, " flags"}, flags_o, ef);
`endif
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                valid_i = 1'($urandom);
                ctrl_i = 3'($urandom); data0_i = 8'($urandom); data1_i = 8'($urandom);
            end
            @(negedge clk);
            chk({tag, " hold_valid"}, valid_o, 1);
            chk({tag, " hold_result"}, result_o, er);
            chk({tag, " hold_err"}, err_o, ee);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk({tag, " drained"}, valid_o, 0);
        chk({tag, " back_idle"}, ready_o, 1);
    endtask

    initial begin
        logic [7:0] mr;
        logic       me;
        int         ml, vcount;
        logic [2:0] mf;
        logic [2:0] rc;
        logic [7:0] ra, rb;

        tbl[0]  = '{3'd0, 8'd200, 8'd100, 5, 8'd44,  1'b0, 1, 3'b010};
        tbl[1]  = '{3'd1, 8'd5,   8'd9,   0, 8'd252, 1'b0, 1, 3'b010};
        tbl[2]  = '{3'd2, 8'd15,  8'd17,  2, 8'd255, 1'b0, 9, 3'b000};
        tbl[3]  = '{3'd2, 8'd16,  8'd16,  0, 8'd0,   1'b0, 9, 3'b101};
        tbl[4]  = '{3'd3, 8'd200, 8'd7,   5, 8'd28,  1'b0, 9, 3'b000};
        tbl[5]  = '{3'd4, 8'd200, 8'd7,   1, 8'd4,   1'b0, 9, 3'b000};
        tbl[6]  = '{3'd3, 8'd9,   8'd0,   5, 8'd255, 1'b1, 1, 3'b000};
        tbl[7]  = '{3'd4, 8'd9,   8'd0,   0, 8'd9,   1'b1, 1, 3'b000};
        tbl[8]  = '{3'd5, 8'd3,   8'd4,   2, 8'd0,   1'b1, 1, 3'b100};
        tbl[9]  = '{3'd0, 8'd0,   8'd0,   0, 8'd0,   1'b0, 1, 3'b100};
        tbl[10] = '{3'd3, 8'd255, 8'd1,   0, 8'd255, 1'b0, 9, 3'b000};
        tbl[11] = '{3'd4, 8'd7,   8'd200, 0, 8'd7,   1'b0, 9, 3'b000};
        tbl[12] = '{3'd1, 8'd9,   8'd5,   0, 8'd4,   1'b0, 1, 3'b000};

        repeat (2) @(negedge clk);
        chk("rst valid", valid_o, 0);
        chk("rst result", result_o, 0);
        chk("rst err", err_o, 0);
        chk("rst ready", ready_o, 1);
`ifdef ALU_MC_FLAGS_EN
        chk("rst flags", flags_o, 0);
`endif
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].hold,
                i % 2 == 0, tbl[i].r, tbl[i].e, tbl[i].lat, tbl[i].f);
        end

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            model(rc, ra, rb, mr, me, ml, mf);
            run($sformatf("rnd%0d op%0d %0d,%0d", i, rc, ra, rb), rc, ra, rb,
                int'($urandom_range(0, 3)), 1'b1, mr, me, ml, mf);
        end

        // Abort a multiply in its 4th BUSY cycle
        @(negedge clk);
        valid_i = 1'b1; ctrl_i = 3'd2; data0_i = 8'd15; data1_i = 8'd17;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy", ready_o, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort valid", valid_o, 0);
        chk("abort result", result_o, 0);
        chk("abort err", err_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        vcount = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (valid_o) vcount++;
        end
        chk("abort no_valid", vcount, 0);
        chk("abort ready", ready_o, 1);
        run("post_abort add", 3'd0, 8'd1, 8'd1, 0, 1'b0, 8'd2, 1'b0, 1, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
